// File: rtl/lif_pkg.sv
// lif_pkg: shared FSM state type, default neuron constants and index-width helper
package lif_pkg;
  typedef enum logic [1:0] {IDLE, UPDATE, FLUSH} lif_state_e;
  localparam int LIF_N = 8;
  localparam int LIF_W = 8;
  localparam int LIF_THRESHOLD = 128;
  localparam int LIF_BETA_SHIFT = 3;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lif_update_unit.sv
// lif_update_unit: combinational leak, weighted add, saturate and threshold for one neuron
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int W = LIF_W,
  parameter int THRESHOLD = LIF_THRESHOLD,
  parameter int BETA_SHIFT = LIF_BETA_SHIFT
) (
  input  logic [W-1:0] v_i,
  input  logic         cur_i,
  input  logic [W-1:0] weight_i,
  output logic [W-1:0] v_o,
  output logic         spike_o
);
  localparam logic [W-1:0] TH = W'(THRESHOLD);
  logic [W:0]   sum;
  logic [W-1:0] sat;
  always_comb begin
    sum = {1'b0, v_i - (v_i >> BETA_SHIFT)} + (cur_i ? {1'b0, weight_i} : '0);
    sat = sum[W] ? '1 : sum[W-1:0];
    spike_o = sat >= TH;
    v_o = spike_o ? '0 : sat;
  end
endmodule

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: time-multiplexed LIF neuron sequencer with spike event stream (option LIF_REFRACTORY_EN)
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS = LIF_N,
  parameter int W = LIF_W,
  parameter int THRESHOLD = LIF_THRESHOLD,
  parameter int BETA_SHIFT = LIF_BETA_SHIFT,
  localparam int IW = idx_w(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_i,
  input  logic [N_NEURONS-1:0] current_i,
  input  logic [W-1:0]         weight_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [IW-1:0]        evt_id_o,
  output logic [N_NEURONS-1:0] spike_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overrun_o,
  input  logic [IW-1:0]        dbg_idx_i,
  output logic [W-1:0]         dbg_state_o
);
  lif_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, evt_id_q, evt_id_d;
  logic [N_NEURONS-1:0] cur_q, cur_d, acc_q, acc_d, spike_q, spike_d;
  logic [W-1:0] wgt_q, wgt_d;
  logic [W-1:0] mem_q [N_NEURONS];
  logic [W-1:0] mem_d [N_NEURONS];
  logic evt_valid_q, evt_valid_d, overrun_q, overrun_d;
  logic [W-1:0] v_upd, v_new;
  logic spk_upd, spk_new, stall, flush_ok;
  lif_update_unit #(.W(W), .THRESHOLD(THRESHOLD), .BETA_SHIFT(BETA_SHIFT)) u_upd (
    .v_i(mem_q[idx_q]),
    .cur_i(cur_q[idx_q]),
    .weight_i(wgt_q),
    .v_o(v_upd),
    .spike_o(spk_upd)
  );
`ifdef LIF_REFRACTORY_EN
  logic [N_NEURONS-1:0] ref_q, ref_d;
  assign v_new = ref_q[idx_q] ? '0 : v_upd;
  assign spk_new = !ref_q[idx_q] && spk_upd;
`else
  assign v_new = v_upd;
  assign spk_new = spk_upd;
`endif
  assign stall = evt_valid_q && !evt_ready_i && spk_new;
  assign flush_ok = !evt_valid_q || evt_ready_i;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cur_d = cur_q;
    wgt_d = wgt_q;
    acc_d = acc_q;
    spike_d = spike_q;
    mem_d = mem_q;
    evt_valid_d = evt_valid_q && !evt_ready_i;
    evt_id_d = evt_id_q;
    overrun_d = overrun_q || (tick_i && state_q != IDLE);
`ifdef LIF_REFRACTORY_EN
    ref_d = ref_q;
`endif
    case (state_q)
      IDLE: if (tick_i) begin
        state_d = UPDATE;
        idx_d = '0;
        cur_d = current_i;
        wgt_d = weight_i;
        acc_d = '0;
      end
      UPDATE: if (!stall) begin
        mem_d[idx_q] = v_new;
        acc_d[idx_q] = spk_new;
`ifdef LIF_REFRACTORY_EN
        ref_d[idx_q] = spk_new;
`endif
        evt_valid_d = spk_new || evt_valid_d;
        evt_id_d = spk_new ? idx_q : evt_id_q;
        idx_d = idx_q + 1'b1;
        state_d = idx_q == IW'(N_NEURONS - 1) ? FLUSH : UPDATE;
      end
      FLUSH: if (flush_ok) begin
        state_d = IDLE;
        spike_d = acc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cur_q <= '0;
      wgt_q <= '0;
      acc_q <= '0;
      spike_q <= '0;
      mem_q <= '{default: '0};
      evt_valid_q <= 1'b0;
      evt_id_q <= '0;
      overrun_q <= 1'b0;
`ifdef LIF_REFRACTORY_EN
      ref_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cur_q <= cur_d;
      wgt_q <= wgt_d;
      acc_q <= acc_d;
      spike_q <= spike_d;
      mem_q <= mem_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q <= evt_id_d;
      overrun_q <= overrun_d;
`ifdef LIF_REFRACTORY_EN
      ref_q <= ref_d;
`endif
    end
  end
  assign done_o = state_q == FLUSH && flush_ok;
  assign spike_o = done_o ? acc_q : spike_q;
  assign busy_o = state_q != IDLE;
  assign evt_valid_o = evt_valid_q;
  assign evt_id_o = evt_id_q;
  assign overrun_o = overrun_q;
  assign dbg_state_o = mem_q[dbg_idx_i];
endmodule

// File: doc/lif_tdm_scheduler.md
Name: lif_tdm_scheduler

Overview:
Time-multiplexed controller for leaky integrate-and-fire neurons. One shared update datapath serves N_NEURONS membrane states held in a register file. The block processes one neuron per cycle after each timestep tick and streams resulting spike events over a valid/ready interface. It replaces N parallel neuron instances when area matters and feeds downstream spike summation or output-neuron logic.

Parameters:
N_NEURONS, 8, number of neurons sequenced (power of 2, ≥2)
W, 8, membrane state width in bits
THRESHOLD, 128, spike threshold (unsigned, W bits)
BETA_SHIFT, 3, leak shift; beta = 1 - 2^-BETA_SHIFT (3 → 0.875)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
tick_i  in  1  start one timestep (single-cycle pulse)
current_i  in  N_NEURONS  per-neuron input spike, sampled on accepted tick
weight_i  in  W  input weight added when a neuron's current bit is set, sampled on accepted tick
evt_valid_o  out  1  spike event available
evt_ready_i  in  1  downstream accepts event
evt_id_o  out  clog2(N_NEURONS)  index of spiking neuron
spike_o  out  N_NEURONS  spike vector of last completed timestep
busy_o  out  1  timestep in progress
done_o  out  1  one-cycle pulse at timestep completion
overrun_o  out  1  sticky: tick_i arrived while busy
dbg_idx_i  in  clog2(N_NEURONS)  debug read index
dbg_state_o  out  W  combinational read of membrane[dbg_idx_i]

Behaviour:
- Reset (clk edge with rst_n=0): all membranes 0, FSM IDLE, idx 0, evt_valid_o 0, evt_id_o 0, spike_o 0, busy_o 0, done_o 0, overrun_o 0. Reset mid-UPDATE aborts the timestep; the pending event is dropped.
- FSM states: IDLE, UPDATE, FLUSH.
  - IDLE: on tick_i, latch current_i and weight_i, clear the spike accumulator, idx←0, go to UPDATE. busy_o=1 from the next cycle.
  - UPDATE: update neuron idx each unstalled cycle. Stall holds idx and all state when evt_valid_o=1 and evt_ready_i=0 and the current neuron would spike. After idx=N_NEURONS-1 is written, go to FLUSH.
  - FLUSH: wait until evt_valid_o=0 or the event handshake completes. Then copy the accumulator to spike_o, pulse done_o, and go to IDLE with busy_o=0.
- Update arithmetic, unsigned:
  - leak = v >> BETA_SHIFT
  - s = (v - leak) + (cur[idx] ? weight : 0), computed in W+1 bits
  - saturate s to 2^W-1
  - if s ≥ THRESHOLD: spike=1 and v←0; else v←s
- Event output: a spike loads a single-entry output register (evt_valid_o←1, evt_id_o←idx) at the same edge as the state write. The register clears on handshake unless reloaded that same cycle. Events leave in ascending index order.
- Latency with no stalls:
  - tick at cycle T → neuron i written at edge T+1+i
  - done_o asserted cycle T+N_NEURONS+1, FLUSH taking 1 cycle
  - spike_o valid in the same cycle as done_o
- tick_i while busy_o=1 or in the done_o cycle: ignored, overrun_o←1 (cleared only by reset).
- tick_i and reset in the same cycle: reset wins.

Optional Feature:
LIF_REFRACTORY_EN
- Defined: adds a per-neuron refractory bit, set when the neuron spikes. On its next update the neuron ignores input and leak, holds v=0, cannot spike, and the bit clears.
- Undefined: no refractory bits; every update follows the arithmetic above.

Decomposition:
- Package lif_pkg: FSM state enum, default W/THRESHOLD/BETA_SHIFT constants, index-width helper.
- Sub-module lif_update_unit: combinational leak/add/saturate/threshold for one neuron, reused by future parallel variants.

Test Plan:
Defaults: N=8, W=8, THRESHOLD=128, BETA_SHIFT=3, evt_ready_i=1 unless stated.
1. Reset release → all outputs 0, busy_o=0, dbg_state_o=0 for all indices.
2. current_i=8'h01, weight_i=100:
   - tick 1 → v0=100, no event
   - tick 2 → s=188 ≥128, event id 0, spike_o=8'h01, v0=0
   - done_o exactly 9 cycles after each tick
3. v0=100, current_i=0: tick → v0=88; tick → v0=77; no events, spike_o=0.
4. current_i=8'hFF, weight_i=255, evt_ready_i low 5 cycles then high → saturation path, stalls observed, events ids 0..7 in order, busy_o held, single done_o afterward, spike_o=8'hFF.
5. tick_i during UPDATE → ignored, overrun_o=1 and stays 1; the next timestep after done_o runs normally.
6. rst_n low at idx=3 with evt_valid_o=1 → next cycle evt_valid_o=0, busy_o=0, all membranes 0. With LIF_REFRACTORY_EN: a neuron that spiked stays at 0 for one timestep with current set.
